data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder: the slave end of the CPU's data-memory request interface.
- It accepts one word read/write request, holds it for a programmable number of wait cycles, then returns a single-cycle response with read data and an error flag.
- Sits between the CPU top's load/store datapath (address from ALU result, write data from register B) and a word-organised storage array.
- Lets the multi-cycle CPU be exercised against non-zero memory latency.

---
 rtl/data_mem_responder.sv | 134 +++++++++++++
 tb/tb_data_mem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Slave end of the CPU data-memory request interface. Accepts one word
//   read or write request, holds it for LATENCY cycles, then returns a
//   one-cycle response carrying read data and an error flag.
//
// Parameters
//   DEPTH   : number of 32-bit words in the array (power of two, >= 4)
//   ADDR_W  : byte address width
//   LATENCY : cycles from acceptance to response (1..15)
//
// Ports
//   CLK        in   rising-edge clock
//   RST        in   asynchronous active-high reset
//   req_valid  in   request present, sampled only while idle
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   busy       out  request in flight, new requests ignored
//   resp_valid out  one-cycle response strobe
//   resp_rdata out  read data, held until the next response
//   resp_err   out  misaligned or out-of-range access
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic              w_accept;
  logic              w_enter_resp;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [31:0]       w_wdata;
  logic [IDX_W-1:0]  w_idx;
  logic              w_err;

  assign w_accept = (r_state == IDLE) && req_valid;

  // With LATENCY=1 the access happens on the acceptance edge itself, so the
  // operands come straight from the request pins rather than the latch.
  assign w_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_we    = (r_state == IDLE) ? req_we    : r_we;
  assign w_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
  assign w_idx   = w_addr[IDX_W+1:2];

  // Every address bit above the word index must be zero: no aliasing.
  assign w_err = (w_addr[1:0] != 2'b00) || ((w_addr >> (IDX_W + 2)) != '0);

  always_comb begin
    w_next       = r_state;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: if (req_valid) begin
        if (LATENCY == 1) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_next = WAIT;
        end
      end
      WAIT: if (r_cnt == 4'd0) begin
        w_next       = RESP;
        w_enter_resp = 1'b1;
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_we    <= req_we;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_INIT;
      end else if (r_state == WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (!w_err && !w_we) ? r_mem[w_idx] : 32'd0;
      end else if (r_state == RESP) begin
        r_err <= 1'b0;
      end
    end
  end

  // Storage is not reset. A write commits only on the edge entering RESP;
  // reset forces IDLE, so a request caught in WAIT never reaches the array.
  always_ff @(posedge CLK) begin
    if (w_enter_resp && w_we && !w_err)
      r_mem[w_idx] <= w_wdata;
  end

  assign busy       = (r_state != IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int NI = 3;
  localparam int LAT [NI] = '{2, 3, 1};

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        CLK = 1'b0;
  logic        rst        [NI];
  logic        req_valid  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        busy       [NI];
  logic        resp_valid [NI];
  logic [31:0] resp_rdata [NI];
  logic        resp_err   [NI];

  logic [31:0] mdl [NI][64];
  exp_t        sb[$];
  int          rcount [NI];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(64), .ADDR_W(32), .LATENCY(2)) u_l2 (
    .CLK(CLK), .RST(rst[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .busy(busy[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

  data_mem_responder #(.DEPTH(64), .ADDR_W(32), .LATENCY(3)) u_l3 (
    .CLK(CLK), .RST(rst[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .busy(busy[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

  data_mem_responder #(.DEPTH(64), .ADDR_W(32), .LATENCY(1)) u_l1 (
    .CLK(CLK), .RST(rst[2]), .req_valid(req_valid[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .busy(busy[2]),
    .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

  // Scoreboard monitor: every response strobe pops one expected entry.
  always @(negedge CLK) begin
    for (int k = 0; k < NI; k++) begin
      if (resp_valid[k] === 1'b1) begin
        exp_t e;
        rcount[k] = rcount[k] + 1;
        checks = checks + 1;
        if (sb.size() == 0) begin
          errors = errors + 1;
          $display("FAIL unexpected_resp inst=%0d cyc=%0d", k, cyc);
        end else begin
          e = sb.pop_front();
          if (e.k !== k || e.due !== cyc || resp_rdata[k] !== e.rdata || resp_err[k] !== e.err) begin
            errors = errors + 1;
            $display("FAIL resp inst=%0d cyc=%0d rdata=%h err=%b : want inst=%0d cyc=%0d rdata=%h err=%b",
                     k, cyc, resp_rdata[k], resp_err[k], e.k, e.due, e.rdata, e.err);
          end
        end
      end
    end
  end

  function automatic exp_t model(int k, logic we, logic [31:0] addr, logic [31:0] wdata);
    exp_t e;
    logic [5:0] idx;
    idx     = addr[7:2];
    e.k     = k;
    e.err   = (addr[1:0] != 2'b00) || (addr >= 32'h100);
    e.rdata = (!we && !e.err) ? mdl[k][idx] : 32'd0;
    if (we && !e.err) mdl[k][idx] = wdata;
    e.due   = 0;
    return e;
  endfunction

  task automatic drain(int k);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge CLK); #1;
      n++;
    end
    checks = checks + 1;
    if (sb.size() != 0) begin
      errors = errors + 1;
      $display("FAIL timeout inst=%0d pending=%0d want=0", k, sb.size());
      sb.delete();
    end
  endtask

  // One request: accept, check busy, wait for response, check return to idle.
  task automatic issue(int k, logic we, logic [31:0] addr, logic [31:0] wdata);
    exp_t e;
    @(negedge CLK);
    req_valid[k] = 1'b1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata;
    @(posedge CLK); #1;
    req_valid[k] = 1'b0;
    e = model(k, we, addr, wdata);
    e.due = cyc + LAT[k] - 1;
    sb.push_back(e);
    checks = checks + 1;
    if (busy[k] !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL busy_after_accept inst=%0d got=%b want=1", k, busy[k]);
    end
    drain(k);
    @(posedge CLK); #1;
    checks = checks + 1;
    if (busy[k] !== 1'b0 || resp_valid[k] !== 1'b0 || resp_err[k] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL back_to_idle inst=%0d busy=%b valid=%b err=%b want 0 0 0",
               k, busy[k], resp_valid[k], resp_err[k]);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_we[k] = 1'b0;
      req_addr[k] = 32'd0; req_wdata[k] = 32'd0; rcount[k] = 0;
    end
    #20;
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      for (int k = 0; k < NI; k++) begin
        checks = checks + 1;
        if (busy[k] !== 1'b0 || resp_valid[k] !== 1'b0 || resp_rdata[k] !== 32'd0 || resp_err[k] !== 1'b0) begin
          errors = errors + 1;
          $display("FAIL reset_idle inst=%0d busy=%b valid=%b rdata=%h err=%b want 0 0 0 0",
                   k, busy[k], resp_valid[k], resp_rdata[k], resp_err[k]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    issue(0, 1'b1, 32'h8, 32'hDEADBEEF);
    issue(0, 1'b0, 32'h8, 32'h0);
  endtask

  task automatic test_errors();
    issue(0, 1'b1, 32'h4, 32'hCAFEF00D);
    issue(0, 1'b1, 32'h6, 32'h55555555);   // misaligned: must not touch word 1
    issue(0, 1'b0, 32'h4, 32'h0);
    issue(0, 1'b0, 32'h100, 32'h0);        // first out-of-range byte address
    issue(0, 1'b0, 32'h8000_0008, 32'h0);  // high bits set: no aliasing onto 0x8
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   base;
    issue(1, 1'b1, 32'h0, 32'h0BADF00D);
    base = rcount[1];
    @(negedge CLK);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h0; req_wdata[1] = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (i % 4 == 0) begin
        e = model(1, 1'b0, 32'h0, 32'h0);
        e.due = cyc + LAT[1] - 1;
        sb.push_back(e);
      end
    end
    req_valid[1] = 1'b0;
    drain(1);
    repeat (6) @(negedge CLK);
    checks = checks + 1;
    if (rcount[1] - base !== 3) begin
      errors = errors + 1;
      $display("FAIL b2b_pulses got=%0d want=3", rcount[1] - base);
    end
  endtask

  task automatic test_reset_mid();
    issue(0, 1'b1, 32'h10, 32'h11111111);
    @(negedge CLK);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10; req_wdata[0] = 32'h12345678;
    @(posedge CLK); #1;
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    #1;
    checks = checks + 1;
    if (busy[0] !== 1'b0 || resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'd0 || resp_err[0] !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_mid inst=0 busy=%b valid=%b rdata=%h err=%b want 0 0 0 0",
               busy[0], resp_valid[0], resp_rdata[0], resp_err[0]);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    rst[0] = 1'b0;
    repeat (4) @(negedge CLK);
    issue(0, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_latency1();
    issue(2, 1'b1, 32'hFC, 32'hA5A5A5A5);
    issue(2, 1'b0, 32'hFC, 32'h0);
    issue(2, 1'b0, 32'h2, 32'h0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_latency1();
    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
